// File: rtl/div_iter_param.sv
// Radix-2 restoring iterative divider, signed/unsigned, with divide-by-zero detection and flush.
// Define DIV_LZC_SKIP_EN to skip leading-zero quotient bits (results identical, shorter latency).
module div_iter_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_zero;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_zero;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_q;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nx;

  // Magnitudes as unsigned WIDTH bits; negating MIN yields 2^(WIDTH-1) exactly.
  assign w_mag_a  = r_sign_a ? -r_a : r_a;
  assign w_mag_b  = r_sign_b ? -r_b : r_b;
  assign w_rem_sh = {r_rem, r_shift[WIDTH-1]};
  assign w_qbit   = (w_rem_sh >= {1'b0, w_mag_b});
  assign w_rem_nx = w_qbit ? WIDTH'(w_rem_sh - {1'b0, w_mag_b}) : w_rem_sh[WIDTH-1:0];

`ifdef DIV_LZC_SKIP_EN
  function automatic logic [CNT_W-1:0] lzc(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n = CNT_W'(WIDTH - 1 - i);
    end
    return n;
  endfunction

  logic [CNT_W-1:0] w_la;
  logic             w_a_lt_b;
  assign w_la     = lzc(w_mag_a);
  assign w_a_lt_b = (w_mag_a < w_mag_b);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_zero      <= 1'b0;
      r_rem       <= '0;
      r_shift     <= '0;
      r_q         <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= dividend;
            r_b        <= divisor;
            r_sign_a   <= is_signed & dividend[WIDTH-1];
            r_sign_b   <= is_signed & divisor[WIDTH-1];
            r_in_ready <= 1'b0;
            r_state    <= S_PREP;
          end
        end
        S_PREP: begin
          r_rem <= '0;
          r_q   <= '0;
          if (r_b == '0) begin
            // Routed through FIX so out_valid appears two edges after the handshake.
            r_zero  <= 1'b1;
            r_state <= S_FIX;
          end else begin
            r_zero <= 1'b0;
`ifdef DIV_LZC_SKIP_EN
            if (w_a_lt_b) begin
              r_rem   <= w_mag_a;
              r_state <= S_FIX;
            end else begin
              r_shift <= w_mag_a << w_la;
              r_cnt   <= CNT_W'(WIDTH) - w_la;
              r_state <= S_ITER;
            end
`else
            r_shift <= w_mag_a;
            r_cnt   <= CNT_W'(WIDTH);
            r_state <= S_ITER;
`endif
          end
        end
        S_ITER: begin
          r_rem   <= w_rem_nx;
          r_shift <= r_shift << 1;
          r_q     <= {r_q[WIDTH-2:0], w_qbit};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_a;
            r_div_zero  <= 1'b1;
          end else begin
            r_quotient  <= (r_sign_a ^ r_sign_b) ? -r_q : r_q;
            r_remainder <= r_sign_a ? -r_rem : r_rem;
            r_div_zero  <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench for div_iter_param: a 32-bit and an 8-bit instance checked against an
// arithmetic reference model (also honours DIV_LZC_SKIP_EN for the latency expectation).
module tb_div_iter_param;

  localparam int W0 = 32;
  localparam int W1 = 8;

  typedef struct {
    logic [63:0] a, b;
    logic        s;
    logic [63:0] q, r;
    logic        dz;
    int          lat;
    int          t;
    logic        seen;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        iv[2];
  logic        sgn[2];
  logic        ordy[2];
  logic [63:0] dvd[2];
  logic [63:0] dvs[2];

  logic          rdy0, ov0, dz0, rdy1, ov1, dz1;
  logic [W0-1:0] q0, r0;
  logic [W1-1:0] q1, r1;

  div_iter_param #(.WIDTH(W0)) u_dut32 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(iv[0]), .in_ready(rdy0), .is_signed(sgn[0]),
    .dividend(dvd[0][W0-1:0]), .divisor(dvs[0][W0-1:0]),
    .out_valid(ov0), .out_ready(ordy[0]),
    .quotient(q0), .remainder(r0), .div_zero(dz0)
  );

  div_iter_param #(.WIDTH(W1)) u_dut8 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(iv[1]), .in_ready(rdy1), .is_signed(sgn[1]),
    .dividend(dvd[1][W1-1:0]), .divisor(dvs[1][W1-1:0]),
    .out_valid(ov1), .out_ready(ordy[1]),
    .quotient(q1), .remainder(r1), .div_zero(dz1)
  );

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stray_prints = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic int lzc_ref(logic [63:0] m, int w);
    for (int i = w - 1; i >= 0; i--) if (m[i]) return w - 1 - i;
    return w;
  endfunction

  // Reference: plain integer division on sign-extended values, truncated to w bits.
  function automatic exp_t model(int w, logic [63:0] a_in, logic [63:0] b_in, logic s);
    exp_t        e;
    logic [63:0] mask;
    longint      sa, sb, ma, mb;
    mask = (64'd1 << w) - 64'd1;
    e.a = a_in & mask;
    e.b = b_in & mask;
    e.s = s;
    e.seen = 1'b0;
    e.t = 0;
    sa = longint'(e.a);
    sb = longint'(e.b);
    if (s && e.a[w-1]) sa = sa - (longint'(1) << w);
    if (s && e.b[w-1]) sb = sb - (longint'(1) << w);
    if (e.b == 64'd0) begin
      e.q = mask;
      e.r = e.a;
      e.dz = 1'b1;
      e.lat = 2;
    end else begin
      e.q = 64'(sa / sb) & mask;
      e.r = 64'(sa % sb) & mask;
      e.dz = 1'b0;
      e.lat = w + 2;
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
`ifdef DIV_LZC_SKIP_EN
      e.lat = (ma < mb) ? 2 : (w - lzc_ref(64'(ma), w) + 2);
`else
      if (ma < 0 || mb < 0) e.lat = -1;
`endif
    end
    return e;
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic ov_of(int k);
    return (k == 0) ? ov0 : ov1;
  endfunction

  function automatic logic rdy_of(int k);
    return (k == 0) ? rdy0 : rdy1;
  endfunction

  // Stimulus side: expected responses are pushed at the accepting edge.
  always @(posedge clk) begin
    exp_t e;
    if (!resetn || flush) begin
      sb0.delete();
      sb1.delete();
    end else begin
      if (iv[0] && rdy0) begin
        e = model(W0, dvd[0], dvs[0], sgn[0]);
        e.t = cyc;
        sb0.push_back(e);
      end
      if (iv[1] && rdy1) begin
        e = model(W1, dvd[1], dvs[1], sgn[1]);
        e.t = cyc;
        sb1.push_back(e);
      end
      if (ov0 && ordy[0] && sb0.size() > 0) void'(sb0.pop_front());
      if (ov1 && ordy[1] && sb1.size() > 0) void'(sb1.pop_front());
    end
    cyc <= cyc + 1;
  end

  task automatic mon(int k, int w, logic ov, logic [63:0] q, logic [63:0] r, logic dz);
    exp_t e;
    if (!ov) return;
    if (qsize(k) == 0) begin
      n_cmp++;
      n_fail++;
      if (stray_prints < 10) $display("FAIL out_valid_w%0d: got 1 with no result pending, expected 0", w);
      stray_prints++;
      return;
    end
    e = (k == 0) ? sb0[0] : sb1[0];
    chk($sformatf("quotient_w%0d", w), q, e.q);
    chk($sformatf("remainder_w%0d", w), r, e.r);
    chk($sformatf("div_zero_w%0d", w), 64'(dz), 64'(e.dz));
    if (!e.seen) begin
      chk($sformatf("latency_w%0d", w), 64'(cyc - e.t - 1), 64'(e.lat));
      $display("txn w%0d signed=%0d a=0x%0h b=0x%0h -> q=0x%0h r=0x%0h dz=%0d lat=%0d",
               w, e.s, e.a, e.b, q, r, dz, cyc - e.t - 1);
      e.seen = 1'b1;
      if (k == 0) sb0[0] = e; else sb1[0] = e;
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      mon(0, W0, ov0, 64'(q0), 64'(r0), dz0);
      mon(1, W1, ov1, 64'(q1), 64'(r1), dz1);
    end
  end

  task automatic do_op(int k, logic [63:0] a, logic [63:0] b, logic s);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    dvd[k] = a;
    dvs[k] = b;
    sgn[k] = s;
    iv[k] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (rdy_of(k)) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    iv[k] = 1'b0;
    dvd[k] = {$urandom, $urandom};
    dvs[k] = {$urandom, $urandom};
    sgn[k] = ~s;
    if (!ok) chk($sformatf("handshake_timeout_k%0d", k), 64'd0, 64'd1);
  endtask

  task automatic wait_done(int k, bit rnd);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (qsize(k) == 0 && !ov_of(k)) begin
        ordy[k] = 1'b1;
        return;
      end
      if (rnd) ordy[k] = 1'($urandom_range(0, 1));
    end
    ordy[k] = 1'b1;
    chk($sformatf("result_timeout_k%0d", k), 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] rnd_opnd(int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'($urandom_range(1, 20));
      2:       return 64'd1 << (w - 1);
      3:       return mask;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  initial begin
    logic [63:0] da[10];
    logic [63:0] db[10];
    logic        ds[10];
    int          k;
    int          w;
    da = '{64'd100, 64'hFFFFFFF9, 64'd7, 64'h80000000, 64'hFFFFFFFF, 64'd5, 64'd5, 64'd3, 64'd9, 64'd1000};
    db = '{64'd7, 64'd2, 64'hFFFFFFFE, 64'hFFFFFFFF, 64'd1, 64'd0, 64'd0, 64'd7, 64'd3, 64'd3};
    ds = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; sgn[i] = 1'b0; ordy[i] = 1'b1; dvd[i] = '0; dvs[i] = '0;
    end

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(rdy0), 64'd1);
    chk("reset_out_valid", 64'(ov0), 64'd0);
    chk("reset_quotient", 64'(q0), 64'd0);
    chk("reset_remainder", 64'(r0), 64'd0);
    chk("reset_div_zero", 64'(dz0), 64'd0);
    chk("reset_in_ready_w8", 64'(rdy1), 64'd1);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(0, da[i], db[i], ds[i]);
      wait_done(0, 1'b0);
    end

    // Backpressure on a divide-by-zero result.
    ordy[0] = 1'b0;
    do_op(0, 64'd5, 64'd0, 1'b0);
    for (int i = 0; i < 20 && !ov0; i++) @(negedge clk);
    chk("hold_out_valid", 64'(ov0), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(rdy0), 64'd0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("accept_out_valid", 64'(ov0), 64'd0);
    chk("accept_in_ready", 64'(rdy0), 64'd1);

    // Flush mid-iteration.
    do_op(0, 64'd1000, 64'd3, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_valid", 64'(ov0), 64'd0);
    chk("flush_in_ready", 64'(rdy0), 64'd1);
    repeat (40) @(negedge clk);
    do_op(0, 64'd9, 64'd3, 1'b0);
    wait_done(0, 1'b0);

    // Reset mid-iteration.
    do_op(0, 64'd1000, 64'd3, 1'b0);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_in_ready", 64'(rdy0), 64'd1);
    chk("rst_quotient", 64'(q0), 64'd0);
    chk("rst_remainder", 64'(r0), 64'd0);
    repeat (40) @(negedge clk);
    do_op(0, 64'd9, 64'd3, 1'b0);
    wait_done(0, 1'b0);

    // Flush coinciding with a would-be handshake.
    @(negedge clk);
    dvd[0] = 64'd50; dvs[0] = 64'd5; sgn[0] = 1'b0; iv[0] = 1'b1; flush = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0; flush = 1'b0;
    chk("flush_hs_in_ready", 64'(rdy0), 64'd1);
    repeat (40) @(negedge clk);

    do_op(1, 64'h81, 64'h03, 1'b1);
    wait_done(1, 1'b0);

    for (int i = 0; i < 120; i++) begin
      k = int'($urandom_range(0, 1));
      w = (k == 0) ? W0 : W1;
      do_op(k, rnd_opnd(w), rnd_opnd(w), 1'($urandom_range(0, 1)));
      wait_done(k, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
